// File: rtl/pipe_ctrl_if.sv
// Handshake and control bundle between the pipeline datapath and pipe_ctrl.
// CNT_WIDTH must match the CNT_WIDTH of the pipe_ctrl instance it is bound to.
interface pipe_ctrl_if #(parameter int CNT_WIDTH = 32);
  logic                 ld_use;
  logic                 br_taken;
  logic                 mdu_req;
  logic                 mdu_done;
  logic                 mem_req;
  logic                 mem_ack;
  logic                 trap;
  logic                 pc_en;
  logic [1:0]           pc_sel;
  logic [3:0]           stage_en;
  logic [3:0]           stage_flush;
  logic                 mem_timeout;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [1:0]           state;

  modport master (
    output ld_use, br_taken, mdu_req, mdu_done, mem_req, mem_ack, trap,
    input  pc_en, pc_sel, stage_en, stage_flush, mem_timeout, stall_cnt, state
  );

  modport slave (
    input  ld_use, br_taken, mdu_req, mdu_done, mem_req, mem_ack, trap,
    output pc_en, pc_sel, stage_en, stage_flush, mem_timeout, stall_cnt, state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: PC enable/select, per-stage enables and flushes,
// memory-wait timeout and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int TO_WIDTH  = 10
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2,
    TRAP     = 2'd3
  } state_t;

  // Control word layout: {pc_en, pc_sel[1:0], stage_en[3:0], stage_flush[3:0]}
  localparam logic [10:0] CTL_RUN   = 11'b1_00_1111_0000;
  localparam logic [10:0] CTL_TRAP  = 11'b1_10_0000_1111;
  localparam logic [10:0] CTL_MEM   = 11'b0_00_0000_0001;
  localparam logic [10:0] CTL_MDU   = 11'b0_00_0011_0010;
  localparam logic [10:0] CTL_BR    = 11'b1_01_1111_1100;
  localparam logic [10:0] CTL_LD    = 11'b0_00_0111_0100;
  localparam logic [10:0] CTL_FLUSH = 11'b0_00_0000_1111;

  state_t               cur;
  state_t               nxt;
  logic [10:0]          ctl;
  logic                 mem_timeout;
  logic [TO_WIDTH-1:0]  to_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic                 to_full;

  assign to_full = &to_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= RUN;
    end else begin
      cur <= nxt;
    end
  end

  // Counts only while staying in MEM_WAIT, so entering the wait always starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (cur == MEM_WAIT && nxt == MEM_WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!ctl[10] && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt         = cur;
    ctl         = CTL_RUN;
    mem_timeout = 1'b0;
    unique case (cur)
      RUN: begin
        if (bus.trap) begin
          ctl = CTL_TRAP;
          nxt = TRAP;
        end else if (bus.mem_req && !bus.mem_ack) begin
          ctl = CTL_MEM;
          nxt = MEM_WAIT;
        end else if (bus.mdu_req && !bus.mdu_done) begin
          ctl = CTL_MDU;
          nxt = MDU_WAIT;
        end else if (bus.br_taken) begin
          ctl = CTL_BR;
        end else if (bus.ld_use) begin
          ctl = CTL_LD;
        end
      end
      MDU_WAIT: begin
        if (bus.trap) begin
          ctl = CTL_TRAP;
          nxt = TRAP;
        end else if (bus.mdu_done) begin
          nxt = RUN;
        end else begin
          ctl = CTL_MDU;
        end
      end
      // A trap cannot be taken while a memory access is outstanding.
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          nxt = RUN;
        end else if (to_full) begin
          ctl         = CTL_TRAP;
          nxt         = TRAP;
          mem_timeout = 1'b1;
        end else begin
          ctl = CTL_MEM;
        end
      end
      TRAP: begin
        ctl = CTL_FLUSH;
        nxt = RUN;
      end
    endcase
    if (!rst) begin
      ctl         = CTL_FLUSH;
      mem_timeout = 1'b0;
    end
  end

  assign bus.pc_en       = ctl[10];
  assign bus.pc_sel      = ctl[9:8];
  assign bus.stage_en    = ctl[7:4];
  assign bus.stage_flush = ctl[3:0];
  assign bus.mem_timeout = mem_timeout;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.state       = cur;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each scenario queues per-cycle expectations
// derived from the control rules and compares them against the DUT outputs.
module tb_pipe_ctrl;

  localparam int CW = 5;
  localparam int TW = 4;

  // Stimulus bits: {trap, mem_ack, mem_req, mdu_done, mdu_req, br_taken, ld_use}
  localparam logic [6:0] I_LD     = 7'h01;
  localparam logic [6:0] I_BR     = 7'h02;
  localparam logic [6:0] I_MREQ   = 7'h04;
  localparam logic [6:0] I_MDONE  = 7'h08;
  localparam logic [6:0] I_MEMREQ = 7'h10;
  localparam logic [6:0] I_MEMACK = 7'h20;
  localparam logic [6:0] I_TRAP   = 7'h40;
  localparam logic [6:0] I_NONE   = 7'h00;

  // Control word: {pc_en, pc_sel, stage_en, stage_flush}
  localparam logic [10:0] C_RUN   = 11'b1_00_1111_0000;
  localparam logic [10:0] C_TRAP  = 11'b1_10_0000_1111;
  localparam logic [10:0] C_MEM   = 11'b0_00_0000_0001;
  localparam logic [10:0] C_MDU   = 11'b0_00_0011_0010;
  localparam logic [10:0] C_BR    = 11'b1_01_1111_1100;
  localparam logic [10:0] C_LD    = 11'b0_00_0111_0100;
  localparam logic [10:0] C_FLUSH = 11'b0_00_0000_1111;

  typedef struct packed {
    logic [6:0]  s;
    logic [1:0]  st;
    logic [10:0] ctl;
    logic        to;
  } row_t;

  typedef struct packed {
    logic [1:0]    st;
    logic [10:0]   ctl;
    logic          to;
    logic [CW-1:0] stall;
  } exp_t;

  logic          clk;
  logic          rst;
  int            total;
  int            bad;
  logic [CW-1:0] exp_stall;
  exp_t          sb[$];

  pipe_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  pipe_ctrl #(.CNT_WIDTH(CW), .TO_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t row(input logic [6:0] s, input logic [1:0] st,
                               input logic [10:0] ctl, input logic to);
    row_t r;
    r.s = s; r.st = st; r.ctl = ctl; r.to = to;
    return r;
  endfunction

  function automatic exp_t expect_of(input row_t r);
    exp_t e;
    e.st = r.st; e.ctl = r.ctl; e.to = r.to; e.stall = exp_stall;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t g;
    g.st    = bus.state;
    g.ctl   = {bus.pc_en, bus.pc_sel, bus.stage_en, bus.stage_flush};
    g.to    = bus.mem_timeout;
    g.stall = bus.stall_cnt;
    return g;
  endfunction

  task automatic drive(input logic [6:0] s);
    {bus.trap, bus.mem_ack, bus.mem_req, bus.mdu_done,
     bus.mdu_req, bus.br_taken, bus.ld_use} = s;
  endtask

  // Advance one clock; the expected stall count follows the expected pc_en.
  task automatic tick(input logic pc_en);
    @(posedge clk);
    if (!pc_en && exp_stall != {CW{1'b1}}) exp_stall = exp_stall + 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t got, want;
    rst = 1'b0;
    exp_stall = '0;
    drive(I_LD | I_MEMREQ);
    @(negedge clk);
    #1;
    sb.push_back(expect_of(row(I_NONE, 2'd0, C_FLUSH, 1'b0)));
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("[TB] FAIL reset_hold: got %h want %h", got, want);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(I_NONE);
    #1;
    sb.push_back(expect_of(row(I_NONE, 2'd0, C_RUN, 1'b0)));
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("[TB] FAIL reset_release: got %h want %h", got, want);
    end
    tick(1'b1);
  endtask

  task automatic test_run_hazards();
    row_t rows[$];
    exp_t got, want;
    rows.push_back(row(I_LD, 2'd0, C_LD, 1'b0));
    rows.push_back(row(I_NONE, 2'd0, C_RUN, 1'b0));
    rows.push_back(row(I_BR | I_LD, 2'd0, C_BR, 1'b0));
    rows.push_back(row(I_MREQ | I_MDONE, 2'd0, C_RUN, 1'b0));
    rows.push_back(row(I_MREQ | I_MDONE | I_LD, 2'd0, C_LD, 1'b0));
    rows.push_back(row(I_MEMREQ | I_MEMACK | I_BR, 2'd0, C_BR, 1'b0));
    rows.push_back(row(I_TRAP | I_MEMREQ | I_MREQ | I_BR | I_LD, 2'd0, C_TRAP, 1'b0));
    rows.push_back(row(7'h7F, 2'd3, C_FLUSH, 1'b0));
    rows.push_back(row(I_MEMREQ | I_MREQ, 2'd0, C_MEM, 1'b0));
    rows.push_back(row(I_MEMACK, 2'd2, C_RUN, 1'b0));
    rows.push_back(row(I_NONE, 2'd0, C_RUN, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(expect_of(rows[i]));
      #1;
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("[TB] FAIL run_hazards row%0d: got %h want %h", i, got, want);
      end
      tick(want.ctl[10]);
    end
  endtask

  task automatic test_mdu();
    row_t          rows[$];
    exp_t          got, want;
    logic [CW-1:0] target;
    target = exp_stall + 5;
    rows.push_back(row(I_MREQ, 2'd0, C_MDU, 1'b0));
    for (int k = 0; k < 4; k++) rows.push_back(row(I_MREQ, 2'd1, C_MDU, 1'b0));
    rows.push_back(row(I_MREQ | I_MDONE, 2'd1, C_RUN, 1'b0));
    rows.push_back(row(I_NONE, 2'd0, C_RUN, 1'b0));
    rows.push_back(row(I_MREQ, 2'd0, C_MDU, 1'b0));
    rows.push_back(row(I_MREQ | I_LD, 2'd1, C_MDU, 1'b0));
    rows.push_back(row(I_MREQ | I_TRAP, 2'd1, C_TRAP, 1'b0));
    rows.push_back(row(I_MDONE, 2'd3, C_FLUSH, 1'b0));
    rows.push_back(row(I_NONE, 2'd0, C_RUN, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(expect_of(rows[i]));
      #1;
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("[TB] FAIL mdu row%0d: got %h want %h", i, got, want);
      end
      if (i == 6) begin
        total++;
        if (bus.stall_cnt !== target) begin
          bad++; $display("[TB] FAIL mdu_stall_cnt: got %0d want %0d", bus.stall_cnt, target);
        end
      end
      tick(want.ctl[10]);
    end
  endtask

  task automatic test_mem();
    row_t rows[$];
    exp_t got, want;
    rows.push_back(row(I_MEMREQ, 2'd0, C_MEM, 1'b0));
    for (int k = 0; k < 15; k++)
      rows.push_back(row(I_MEMREQ | ((k == 3) ? I_TRAP : I_NONE), 2'd2, C_MEM, 1'b0));
    rows.push_back(row(I_MEMREQ, 2'd2, C_TRAP, 1'b1));
    rows.push_back(row(I_MEMACK, 2'd3, C_FLUSH, 1'b0));
    rows.push_back(row(I_NONE, 2'd0, C_RUN, 1'b0));
    rows.push_back(row(I_MEMREQ, 2'd0, C_MEM, 1'b0));
    for (int k = 0; k < 15; k++) rows.push_back(row(I_NONE, 2'd2, C_MEM, 1'b0));
    rows.push_back(row(I_MEMACK, 2'd2, C_RUN, 1'b0));
    rows.push_back(row(I_NONE, 2'd0, C_RUN, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(expect_of(rows[i]));
      #1;
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("[TB] FAIL mem row%0d: got %h want %h", i, got, want);
      end
      tick(want.ctl[10]);
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    exp_t got, want;
    for (int k = 0; k < 3; k++) rows.push_back(row(I_LD, 2'd0, C_LD, 1'b0));
    rows.push_back(row(I_NONE, 2'd0, C_RUN, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(expect_of(rows[i]));
      #1;
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("[TB] FAIL saturation row%0d: got %h want %h", i, got, want);
      end
      tick(want.ctl[10]);
    end
    total++;
    if (bus.stall_cnt !== {CW{1'b1}}) begin
      bad++; $display("[TB] FAIL stall_sat: got %0d want %0d", bus.stall_cnt, {CW{1'b1}});
    end
  endtask

  task automatic test_async_reset();
    row_t rows[$];
    exp_t got, want;
    drive(I_MEMREQ);
    sb.push_back(expect_of(row(I_MEMREQ, 2'd0, C_MEM, 1'b0)));
    #1;
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("[TB] FAIL async_enter: got %h want %h", got, want);
    end
    tick(want.ctl[10]);
    #2;
    rst = 1'b0;
    exp_stall = '0;
    #1;
    sb.push_back(expect_of(row(I_MEMREQ, 2'd0, C_FLUSH, 1'b0)));
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("[TB] FAIL async_reset: got %h want %h", got, want);
    end
    @(negedge clk);
    rst = 1'b1;
    rows.push_back(row(I_MEMREQ, 2'd0, C_MEM, 1'b0));
    rows.push_back(row(I_MEMACK, 2'd2, C_RUN, 1'b0));
    rows.push_back(row(I_NONE, 2'd0, C_RUN, 1'b0));
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(expect_of(rows[i]));
      #1;
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("[TB] FAIL async_after row%0d: got %h want %h", i, got, want);
      end
      tick(want.ctl[10]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive(I_NONE);
    $display("[TB] pipe_ctrl bench start");
    test_reset();
    test_run_hazards();
    test_mdu();
    test_mem();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of the stall-cycle counter.
REQ-002 Parameter TO_WIDTH, default 10: width of the memory-wait timeout counter; timeout fires at all-ones.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 ld_use  in  1  the ID instruction needs the result of the load in EX.
REQ-006 br_taken  in  1  EX has resolved a taken branch or jump.
REQ-007 mdu_req  in  1  EX holds a multi-cycle mul/div.
REQ-008 mdu_done  in  1  MDU result valid; single-cycle pulse.
REQ-009 mem_req / mem_ack  in  1 each  MEM-stage access pending / access complete.
REQ-010 trap  in  1  exception or interrupt committing from WB.
REQ-011 pc_en  out  1  PC register enable.
REQ-012 pc_sel  out  2  PC source: 00 = sequential, 01 = branch target, 10 = trap vector.
REQ-013 stage_en  out  4  pipeline-register enables: [3] IF/ID, [2] ID/EX, [1] EX/MEM, [0] MEM/WB.
REQ-014 stage_flush  out  4  synchronous bubble-insert per register, same bit order.
REQ-015 mem_timeout  out  1  one-cycle pulse on memory-wait timeout.
REQ-016 stall_cnt  out  CNT_WIDTH  count of cycles with pc_en = 0.
REQ-017 state  out  2  FSM state for debug.

Function
REQ-018 FSM states: RUN = 0, MDU_WAIT = 1, MEM_WAIT = 2, TRAP = 3; pc_en, pc_sel, stage_en and stage_flush are combinational from the state and the current inputs.
REQ-019 RUN evaluates conditions in strict priority order: trap > mem stall > mdu stall > br_taken > ld_use > normal.
REQ-020 RUN, trap = 1:
 - pc_en = 1, pc_sel = 10, stage_en = 0000, stage_flush = 1111.
 - Next state TRAP.
REQ-021 RUN, mem_req & !mem_ack:
 - pc_en = 0, stage_en = 0000, stage_flush = 0001.
 - Next state MEM_WAIT; timeout counter cleared to 0.
REQ-022 RUN, mdu_req & !mdu_done:
 - pc_en = 0, stage_en = 0011, stage_flush = 0010.
 - Next state MDU_WAIT.
REQ-022a RUN, mdu_req & mdu_done in the same cycle: no stall; continue down the priority order of REQ-019.
REQ-023 RUN, br_taken:
 - pc_en = 1, pc_sel = 01, stage_en = 1111, stage_flush = 1100.
 - br_taken overrides a simultaneous ld_use.
REQ-024 RUN, ld_use:
 - pc_en = 0, stage_en = 0111, stage_flush = 0100.
 - State stays RUN.
REQ-025 RUN, normal: pc_en = 1, pc_sel = 00, stage_en = 1111, stage_flush = 0000.
REQ-026 MDU_WAIT:
 - trap = 1: outputs of REQ-020; next state TRAP.
 - mdu_done = 1: outputs of REQ-025; next state RUN.
 - Otherwise: outputs of REQ-022; stay in MDU_WAIT.
REQ-027 MEM_WAIT:
 - trap is ignored.
 - mem_ack = 1: outputs of REQ-025; next state RUN.
 - Otherwise: outputs of REQ-021; timeout counter increments.
REQ-028 MEM_WAIT, timeout counter at all-ones with mem_ack = 0:
 - mem_timeout = 1 for that cycle; outputs of REQ-020; next state TRAP.
 - mem_ack arriving in the same cycle wins: no timeout.
REQ-029 TRAP lasts exactly one cycle:
 - pc_en = 0, stage_en = 0000, stage_flush = 1111.
 - All inputs ignored; next state RUN.
REQ-030 stall_cnt increments on every edge where pc_en = 0 and saturates at all-ones.
REQ-031 pc_sel = 00 whenever pc_en = 0.

Reset
REQ-032 While rst = 0:
 - state = RUN; stall_cnt, timeout counter and mem_timeout = 0.
 - pc_en = 0, stage_en = 0000, stage_flush = 1111.
REQ-033 Reset asserted mid-wait (MDU_WAIT or MEM_WAIT) abandons the wait immediately; the first rising edge after deassertion evaluates RUN.

Verification
REQ-034 Bench shall cover at least these directed scenarios:
 - ld_use = 1 for 1 cycle in RUN -> stage_en = 0111, stage_flush = 0100, pc_en = 0; stall_cnt 0 -> 1.
 - br_taken = 1 and ld_use = 1 together -> pc_sel = 01, stage_flush = 1100, stage_en = 1111.
 - mdu_req = 1, mdu_done after 5 cycles -> state = 1 for 5 cycles with stage_en = 0011; RUN on the done cycle; stall_cnt = 5.
 - mem_req = 1, mem_ack never, TO_WIDTH = 4 -> mem_timeout pulses after 15 MEM_WAIT cycles; TRAP for 1 cycle with stage_flush = 1111; then RUN.
 - trap = 1 during MDU_WAIT -> pc_sel = 10, pc_en = 1 that cycle; TRAP next; then RUN.
 - rst = 0 asserted asynchronously in MEM_WAIT -> state = 0, stall_cnt = 0, stage_flush = 1111 immediately, without a clock edge.
